addr_map_cfg_ctrl: RTL and testbench
====================================

ADDR_MAP_CFG_CTRL -- requirements
Module: addr_map_cfg_ctrl

Interface
REQ-001 The block SHALL have parameter NoIndices, default 32'd1: number of valid decoder indices; every rule idx must be < NoIndices.
REQ-002 The block SHALL have parameter NoRules, default 32'd1: number of rule slots in the managed map.
REQ-003 The block SHALL have parameter Napot, default 1'b0: 1 = base/mask rules, which skips the start/end order check.
REQ-004 The block SHALL have parameter SlotWidth, default (NoRules>1)?$clog2(NoRules):1: derived, never overridden.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: clk_i input 1, the clock; rst_i input 1, synchronous active-high reset.
REQ-006 The block SHALL have cfg_valid_i input 1, a rule-write request.
REQ-007 The block SHALL have cfg_ready_o output 1, high when a rule write can be accepted.
REQ-008 The block SHALL have cfg_slot_i input 32, the target shadow slot number.
REQ-009 The block SHALL have cfg_rule_i input addr_map_rule_pkg::addr_map_rule_t, the rule to stage.
REQ-010 The block SHALL have commit_valid_i input 1, a request to validate and apply the shadow map.
REQ-011 The block SHALL have commit_ready_o output 1, high when a commit can be accepted.
REQ-012 The block SHALL have commit_done_o output 1, a one-cycle commit completion pulse.
REQ-013 The block SHALL have commit_err_o output 1, valid with commit_done_o: 1 = rejected.
REQ-014 The block SHALL have err_slot_o output SlotWidth, the first failing rule, valid with commit_err_o.
REQ-015 The block SHALL have slot_err_o output 1, a one-cycle pulse: a write to cfg_slot_i >= NoRules was dropped.
REQ-016 The block SHALL have addr_map_o output addr_map_rule_t [NoRules-1:0], the active map driving the decoder.
REQ-017 The block SHALL have config_ongoing_o output 1, which drives the decoder config_ongoing_i.

Function
REQ-018 The block SHALL implement an FSM with states IDLE, CHECK and APPLY; cfg_ready_o = commit_ready_o = (state==IDLE).
REQ-019 In IDLE, a cfg handshake SHALL write cfg_rule_i into shadow[cfg_slot_i] at the clock edge; an out-of-range slot SHALL leave shadow unchanged and pulse slot_err_o next cycle.
REQ-020 A commit handshake at cycle T SHALL move IDLE->CHECK; a cfg write in the same cycle SHALL land first and be included in the check.
REQ-021 CHECK SHALL use a counter 0..NoRules-1 and test rule i at cycle T+1+i.
REQ-022 A rule SHALL be valid iff idx < NoIndices and (Napot or start_addr < end_addr or end_addr == '0).
REQ-023 The first invalid rule SHALL be latched into err_slot_o; checking SHALL still run all NoRules cycles, giving fixed latency.
REQ-024 After the last check, the FSM SHALL enter APPLY at T+NoRules+1; on pass it SHALL copy addr_map_o <= shadow, and on fail addr_map_o SHALL stay unchanged.
REQ-025 In the APPLY cycle, commit_done_o SHALL be 1 and commit_err_o = fail; then the FSM SHALL return to IDLE.
REQ-026 config_ongoing_o SHALL be 1 throughout CHECK and APPLY.
REQ-027 On a pass, config_ongoing_o SHALL drop at T+NoRules+2.
REQ-028 On a fail, config_ongoing_o SHALL return to its pre-commit value.
REQ-029 addr_map_o SHALL change only on the APPLY edge, all slots atomically; the decoder never sees a partially updated map outside config_ongoing_o.
REQ-030 Shadow SHALL persist after a commit, pass or fail; later writes modify it incrementally.
REQ-031 A rule written with both fields equal SHALL fail the check when Napot=0; with end_addr=='0 it SHALL pass.

Reset
REQ-032 With rst_i high at an edge, state SHALL go to IDLE and the counter to 0.
REQ-033 With rst_i high at an edge, shadow and addr_map_o SHALL reset to all-zero rules.
REQ-034 With rst_i high at an edge, commit_done_o, commit_err_o, slot_err_o and err_slot_o SHALL reset to 0.
REQ-035 With rst_i high at an edge, config_ongoing_o SHALL reset to 1; the decoder stays disabled until the first passing commit.
REQ-036 A reset during CHECK or APPLY SHALL abort the commit with no commit_done_o and restore all REQ-032 to REQ-035 values.

Structure
REQ-037 The package addr_map_cfg_pkg SHALL hold the state enum typedef; the rule type SHALL remain in addr_map_rule_pkg.
REQ-038 One combinational sub-module, addr_map_rule_check, SHALL evaluate REQ-022 for a single rule.

Verification
REQ-039 A bench SHALL check reset then commit of 2 valid rules (NoRules=2, NoIndices=2), {0,0x0,0x1000} and {1,0x1000,0x2000}: done at T+3, err=0, config_ongoing_o low from T+4, addr_map_o equal to shadow.
REQ-040 A bench SHALL check slot 1 = {1,0x3000,0x2000} then commit: done with err=1, err_slot_o=1, addr_map_o unchanged, config_ongoing_o restored.
REQ-041 A bench SHALL check a write with idx=2 (NoIndices=2): commit_err_o=1 and err_slot_o equal to that slot.
REQ-042 A bench SHALL check a write to slot 5 (NoRules=2): slot_err_o pulse and shadow unchanged.
REQ-043 A bench SHALL check a simultaneous cfg write and commit in IDLE: the written rule is checked and applied, and cfg_ready_o=0 during CHECK and APPLY.
REQ-044 A bench SHALL check rst_i asserted at T+1 of a commit: no commit_done_o, config_ongoing_o=1, addr_map_o all zero.

Source files
------------

// File: rtl/addr_map_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addr_map_cfg_pkg
// Description : Types for the address-map configuration controller.
// Revision    : 1.0 - initial release
// ============================================================================
package addr_map_cfg_pkg;

    // Commit sequencer: IDLE accepts writes/commits, CHECK walks the shadow
    // map one rule per cycle, APPLY publishes the verdict for one cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        APPLY = 2'd2
    } cfg_state_e;

endpackage : addr_map_cfg_pkg
`default_nettype wire

// File: rtl/addr_map_rule_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addr_map_rule_pkg
// Description : Address-map rule type shared by the address decoder and its
//               configuration controller. Each rule maps the address range
//               [start_addr, end_addr) onto decoder index idx.
// Revision    : 1.0 - initial release
// ============================================================================
package addr_map_rule_pkg;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;

endpackage : addr_map_rule_pkg
`default_nettype wire

// File: rtl/addr_map_rule_check.sv
`default_nettype none
// ============================================================================
// Module      : addr_map_rule_check
// Description : Combinational legality check for a single address-map rule.
//               A rule is legal when its index addresses an existing decoder
//               port and, for start/end rules, the range is non-empty
//               (end_addr == 0 means "up to the top of the address space").
// Ports       : rule_i  - rule under test
//               valid_o - 1 when the rule is legal
// Revision    : 1.0 - initial release
// ============================================================================
module addr_map_rule_check
    import addr_map_rule_pkg::*;
#(
    parameter int unsigned NoIndices = 32'd1,
    parameter bit          Napot     = 1'b0
) (
    input  addr_map_rule_t rule_i,
    output logic           valid_o
);

    logic w_idx_ok;
    logic w_range_ok;

    assign w_idx_ok   = (rule_i.idx < NoIndices);
    // Base/mask rules have no ordering between their two fields.
    assign w_range_ok = Napot
                      || (rule_i.start_addr < rule_i.end_addr)
                      || (rule_i.end_addr == '0);
    assign valid_o    = w_idx_ok && w_range_ok;

endmodule : addr_map_rule_check
`default_nettype wire

// File: rtl/addr_map_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : addr_map_cfg_ctrl
// Description : Staged configuration of an address-decoder rule map. Rules
//               are written into a shadow map, then a commit checks every
//               shadow rule (fixed NoRules-cycle latency) and, if all are
//               legal, copies the whole shadow map to the active map in one
//               edge. config_ongoing_o holds the decoder off while a commit
//               is in flight and until the first successful commit.
// Ports       : clk_i, rst_i                 - clock, sync active-high reset
//               cfg_valid_i/cfg_ready_o      - rule write handshake
//               cfg_slot_i, cfg_rule_i       - write target slot and rule
//               commit_valid_i/commit_ready_o- commit handshake
//               commit_done_o, commit_err_o  - one-cycle verdict
//               err_slot_o                   - first failing slot
//               slot_err_o                   - dropped out-of-range write
//               addr_map_o                   - active map to the decoder
//               config_ongoing_o             - decoder config_ongoing_i
// Revision    : 1.0 - initial release
// ============================================================================
module addr_map_cfg_ctrl
    import addr_map_rule_pkg::*;
    import addr_map_cfg_pkg::*;
#(
    parameter int unsigned NoIndices = 32'd1,
    parameter int unsigned NoRules   = 32'd1,
    parameter bit          Napot     = 1'b0,
    parameter int unsigned SlotWidth = (NoRules > 32'd1) ? $clog2(NoRules) : 32'd1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cfg_valid_i,
    output logic                         cfg_ready_o,
    input  logic [31:0]                  cfg_slot_i,
    input  addr_map_rule_t               cfg_rule_i,
    input  logic                         commit_valid_i,
    output logic                         commit_ready_o,
    output logic                         commit_done_o,
    output logic                         commit_err_o,
    output logic [SlotWidth-1:0]         err_slot_o,
    output logic                         slot_err_o,
    output addr_map_rule_t [NoRules-1:0] addr_map_o,
    output logic                         config_ongoing_o
);

    localparam logic [SlotWidth-1:0] c_LAST_SLOT = SlotWidth'(NoRules - 32'd1);

    cfg_state_e                   r_state;
    cfg_state_e                   w_state_next;
    logic [SlotWidth-1:0]         r_cnt;
    addr_map_rule_t [NoRules-1:0] r_shadow;
    addr_map_rule_t [NoRules-1:0] r_addr_map;
    logic                         r_fail;
    logic [SlotWidth-1:0]         r_err_slot;
    logic                         r_slot_err;
    logic                         r_ongoing;
    logic                         r_prev_ongoing;

    logic                         w_idle;
    logic                         w_cfg_fire;
    logic                         w_commit_fire;
    logic                         w_slot_ok;
    logic                         w_last;
    logic                         w_rule_ok;
    addr_map_rule_t               w_cur_rule;

    assign w_idle        = (r_state == IDLE);
    assign w_cfg_fire    = cfg_valid_i && w_idle;
    assign w_commit_fire = commit_valid_i && w_idle;
    assign w_slot_ok     = (cfg_slot_i < NoRules);
    assign w_last        = (r_cnt == c_LAST_SLOT);

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_commit_fire) w_state_next = CHECK;
            CHECK:   if (w_last)        w_state_next = APPLY;
            APPLY:                      w_state_next = IDLE;
            default:                    w_state_next = IDLE;
        endcase
    end

    // Rule counter: slot i is examined in the (i+1)-th CHECK cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (r_state == CHECK && !w_last) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Shadow map; a same-cycle write lands before the first check cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_shadow <= '0;
        end else if (w_cfg_fire) begin
            for (int i = 0; i < int'(NoRules); i++) begin
                if (cfg_slot_i == 32'(i)) begin
                    r_shadow[i] <= cfg_rule_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_slot_err <= 1'b0;
        end else begin
            r_slot_err <= w_cfg_fire && !w_slot_ok;
        end
    end

    // ------------------------------------------------------------------
    // Rule check
    // ------------------------------------------------------------------
    always_comb begin
        w_cur_rule = '0;
        for (int i = 0; i < int'(NoRules); i++) begin
            if (r_cnt == SlotWidth'(i)) begin
                w_cur_rule = r_shadow[i];
            end
        end
    end

    addr_map_rule_check #(
        .NoIndices (NoIndices),
        .Napot     (Napot)
    ) u_rule_check (
        .rule_i  (w_cur_rule),
        .valid_o (w_rule_ok)
    );

    // Only the first failing slot is recorded; later failures are ignored
    // but the walk continues so latency never depends on the map contents.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fail     <= 1'b0;
            r_err_slot <= '0;
        end else if (w_commit_fire) begin
            r_fail     <= 1'b0;
            r_err_slot <= '0;
        end else if (r_state == CHECK && !w_rule_ok && !r_fail) begin
            r_fail     <= 1'b1;
            r_err_slot <= r_cnt;
        end
    end

    // ------------------------------------------------------------------
    // Active map and decoder hold-off
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr_map <= '0;
        end else if (r_state == APPLY && !r_fail) begin
            r_addr_map <= r_shadow;
        end
    end

    // The pre-commit value is remembered so a rejected commit leaves the
    // decoder exactly as it was (still disabled if never configured).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ongoing      <= 1'b1;
            r_prev_ongoing <= 1'b1;
        end else if (w_commit_fire) begin
            r_prev_ongoing <= r_ongoing;
            r_ongoing      <= 1'b1;
        end else if (r_state == APPLY) begin
            r_ongoing      <= r_fail ? r_prev_ongoing : 1'b0;
        end
    end

    assign cfg_ready_o      = w_idle;
    assign commit_ready_o   = w_idle;
    assign commit_done_o    = (r_state == APPLY);
    assign commit_err_o     = (r_state == APPLY) && r_fail;
    assign err_slot_o       = r_err_slot;
    assign slot_err_o       = r_slot_err;
    assign addr_map_o       = r_addr_map;
    assign config_ongoing_o = r_ongoing;

endmodule : addr_map_cfg_ctrl
`default_nettype wire

// File: tb/tb_addr_map_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_addr_map_cfg_ctrl
// Description : Self-checking bench for addr_map_cfg_ctrl (NoRules=2,
//               NoIndices=2, start/end rules). Expected commit verdicts and
//               maps come from a bench-side shadow model and are queued when
//               a commit is driven, then popped on commit_done_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addr_map_cfg_ctrl;
    import addr_map_rule_pkg::*;

    localparam int unsigned NR = 2;
    localparam int unsigned NI = 2;

    typedef struct {
        bit                      err;
        logic [0:0]              slot;
        addr_map_rule_t [NR-1:0] map;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [31:0]             cfg_slot;
    addr_map_rule_t          cfg_rule;
    logic                    commit_valid;
    logic                    commit_ready;
    logic                    commit_done;
    logic                    commit_err;
    logic [0:0]              err_slot;
    logic                    slot_err;
    addr_map_rule_t [NR-1:0] addr_map;
    logic                    config_ongoing;

    addr_map_rule_t [NR-1:0] shadow_m;
    addr_map_rule_t [NR-1:0] active_m;
    bit                      ongoing_m;
    exp_t                    sb[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    addr_map_cfg_ctrl #(
        .NoIndices (NI),
        .NoRules   (NR),
        .Napot     (1'b0)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cfg_valid_i      (cfg_valid),
        .cfg_ready_o      (cfg_ready),
        .cfg_slot_i       (cfg_slot),
        .cfg_rule_i       (cfg_rule),
        .commit_valid_i   (commit_valid),
        .commit_ready_o   (commit_ready),
        .commit_done_o    (commit_done),
        .commit_err_o     (commit_err),
        .err_slot_o       (err_slot),
        .slot_err_o       (slot_err),
        .addr_map_o       (addr_map),
        .config_ongoing_o (config_ongoing)
    );

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic addr_map_rule_t mk(input logic [31:0] idx, input logic [31:0] s, input logic [31:0] e);
        addr_map_rule_t r;
        r.idx = idx; r.start_addr = s; r.end_addr = e;
        return r;
    endfunction

    function automatic bit rule_ok(input addr_map_rule_t r);
        return (r.idx < NI) && ((r.start_addr < r.end_addr) || (r.end_addr == 32'd0));
    endfunction

    function automatic exp_t model_commit();
        exp_t e;
        e.err  = 1'b0;
        e.slot = '0;
        for (int i = NR - 1; i >= 0; i--) begin
            if (!rule_ok(shadow_m[i])) begin
                e.err  = 1'b1;
                e.slot = 1'(i);
            end
        end
        e.map = e.err ? active_m : shadow_m;
        return e;
    endfunction

    task automatic model_reset();
        shadow_m  = '0;
        active_m  = '0;
        ongoing_m = 1'b1;
    endtask

    task automatic cfg_write(input logic [31:0] slot, input addr_map_rule_t rule);
        @(negedge clk);
        check_eq("cfg_ready_idle", cfg_ready, 1);
        cfg_valid = 1'b1; cfg_slot = slot; cfg_rule = rule;
        if (slot < NR) shadow_m[slot[0]] = rule;
        @(negedge clk);
        cfg_valid = 1'b0;
        check_eq("slot_err", slot_err, (slot >= NR) ? 1 : 0);
    endtask

    task automatic do_commit(input bit wr, input logic [31:0] slot, input addr_map_rule_t rule);
        exp_t e;
        int   cyc;
        bit   done;
        @(negedge clk);
        check_eq("commit_ready_idle", commit_ready, 1);
        commit_valid = 1'b1;
        if (wr) begin
            cfg_valid = 1'b1; cfg_slot = slot; cfg_rule = rule;
            if (slot < NR) shadow_m[slot[0]] = rule;
        end
        sb.push_back(model_commit());
        @(negedge clk);
        commit_valid = 1'b0;
        cfg_valid    = 1'b0;
        cyc  = 1;
        done = 1'b0;
        while (!done && cyc <= 10) begin
            check_eq("ongoing_busy", config_ongoing, 1);
            check_eq("cfg_ready_busy", cfg_ready, 0);
            if (commit_done) begin
                done = 1'b1;
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("done_latency", cyc, NR + 1);
                    check_eq("commit_err", commit_err, e.err);
                    if (e.err) check_eq("err_slot", err_slot, e.slot);
                    check_eq("map_held_in_apply", addr_map, active_m);
                    active_m = e.map;
                    if (!e.err) ongoing_m = 1'b0;
                end
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) begin
            check_eq("done_timeout", 0, 1);
        end else begin
            @(negedge clk);
            check_eq("done_pulse", commit_done, 0);
            check_eq("ready_after", cfg_ready, 1);
            check_eq("addr_map", addr_map, active_m);
            check_eq("ongoing_after", config_ongoing, ongoing_m);
        end
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; commit_valid = 1'b0;
        cfg_slot = '0; cfg_rule = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check_eq("rst_ready", cfg_ready, 1);
        check_eq("rst_done", commit_done, 0);
        check_eq("rst_err", commit_err, 0);
        check_eq("rst_slot_err", slot_err, 0);
        check_eq("rst_err_slot", err_slot, 0);
        check_eq("rst_ongoing", config_ongoing, 1);
        check_eq("rst_map", addr_map, 0);

        // Two legal rules -> pass
        cfg_write(0, mk(0, 32'h0, 32'h1000));
        cfg_write(1, mk(1, 32'h1000, 32'h2000));
        do_commit(1'b0, 0, '0);

        // Reversed range in slot 1 -> reject, map and ongoing untouched
        cfg_write(1, mk(1, 32'h3000, 32'h2000));
        do_commit(1'b0, 0, '0);

        // Repair slot 1, bad index in slot 0 -> reject at slot 0
        cfg_write(1, mk(1, 32'h2000, 32'h3000));
        cfg_write(0, mk(2, 32'h0, 32'h1000));
        do_commit(1'b0, 0, '0);

        // Out-of-range write is dropped with a one-cycle pulse
        cfg_write(5, mk(0, 32'h5000, 32'h6000));
        @(negedge clk);
        check_eq("slot_err_pulse_end", slot_err, 0);

        // Write and commit together; end_addr==0 rule is legal
        do_commit(1'b1, 0, mk(0, 32'h8000, 32'h0));

        // Equal start/end is an empty range -> reject at slot 1
        cfg_write(1, mk(1, 32'h4000, 32'h4000));
        do_commit(1'b0, 0, '0);

        // Reset in the first CHECK cycle aborts the commit
        cfg_write(1, mk(1, 32'h4000, 32'h5000));
        @(negedge clk);
        commit_valid = 1'b1;
        @(negedge clk);
        commit_valid = 1'b0;
        check_eq("abort_busy", config_ongoing, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 6; k++) begin
            check_eq("abort_no_done", commit_done, 0);
            check_eq("abort_ongoing", config_ongoing, 1);
            check_eq("abort_map", addr_map, 0);
            @(negedge clk);
        end

        // Rejected commit from the unconfigured state keeps decoder disabled
        cfg_write(0, mk(3, 32'h0, 32'h100));
        do_commit(1'b0, 0, '0);

        // Zero-reset shadow rules are all legal once slot 0 is repaired
        do_commit(1'b1, 0, mk(1, 32'h100, 32'h200));

        check_eq("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_addr_map_cfg_ctrl
`default_nettype wire
